// File: rtl/urna_apuracao.sv
// rtl/urna_apuracao.sv - voting tally readout: snapshot, winner scan, BCD slot sequencer
// Optional total-votes slot enabled by defining URNA_APURACAO_TOTAL_EN.
module urna_apuracao #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_skip,
  input  logic [7:0]  i_c1,
  input  logic [7:0]  i_c2,
  input  logic [7:0]  i_c3,
  input  logic [7:0]  i_c4,
  input  logic [7:0]  i_nulo,
  output logic [2:0]  o_slot,
  output logic [15:0] o_bcd,
  output logic        o_show_valid,
  output logic [2:0]  o_winner,
  output logic        o_tie,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SNAP = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_CONV = 3'd4;
  localparam logic [2:0] S_SHOW = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

`ifdef URNA_APURACAO_TOTAL_EN
  localparam logic [2:0] LAST_SLOT = 3'd5;
`else
  localparam logic [2:0] LAST_SLOT = 3'd4;
`endif

  localparam logic [31:0] DWELL_TC = 32'(DWELL - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_snap [5];
`ifdef URNA_APURACAO_TOTAL_EN
  logic [10:0] r_total;
`endif
  logic [7:0]  r_max;
  logic [2:0]  r_max_idx;
  logic        r_tie_flag;
  logic [3:0]  r_cnt;
  logic [10:0] r_bin;
  logic [15:0] r_acc;
  logic [31:0] r_dwell;
  logic [2:0]  r_slot;
  logic [15:0] r_bcd;
  logic        r_show_valid;
  logic [2:0]  r_winner;
  logic        r_tie;
  logic        r_done;

  logic [7:0]  w_cand;
  logic [7:0]  w_max_nx;
  logic [2:0]  w_idx_nx;
  logic        w_tie_nx;
  logic [10:0] w_slot_val;
  logic [15:0] w_adj;
  logic [15:0] w_acc_nx;
  logic [10:0] w_bin_nx;

  // One candidate per CMP cycle; a strictly greater count wins the lead and clears any tie.
  always_comb begin
    w_cand   = r_snap[r_cnt[1:0]];
    w_max_nx = r_max;
    w_idx_nx = r_max_idx;
    w_tie_nx = r_tie_flag;
    if (w_cand > r_max) begin
      w_max_nx = w_cand;
      w_idx_nx = {1'b0, r_cnt[1:0]} + 3'd1;
      w_tie_nx = 1'b0;
    end else if ((w_cand == r_max) && (r_max != 8'd0)) begin
      w_tie_nx = 1'b1;
    end
  end

  always_comb begin
    w_slot_val = 11'd0;
    case (r_slot)
      3'd0:    w_slot_val = {3'b000, r_snap[0]};
      3'd1:    w_slot_val = {3'b000, r_snap[1]};
      3'd2:    w_slot_val = {3'b000, r_snap[2]};
      3'd3:    w_slot_val = {3'b000, r_snap[3]};
      3'd4:    w_slot_val = {3'b000, r_snap[4]};
`ifdef URNA_APURACAO_TOTAL_EN
      3'd5:    w_slot_val = r_total;
`endif
      default: w_slot_val = 11'd0;
    endcase
  end

  // Double-dabble step: correct nibbles >= 5, then shift the binary MSB into the BCD LSB.
  always_comb begin
    w_adj = r_acc;
    for (int n = 0; n < 4; n++) begin
      if (r_acc[n*4 +: 4] >= 4'd5) begin
        w_adj[n*4 +: 4] = r_acc[n*4 +: 4] + 4'd3;
      end
    end
    w_acc_nx = {w_adj[14:0], r_bin[10]};
    w_bin_nx = {r_bin[9:0], 1'b0};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      for (int k = 0; k < 5; k++) begin
        r_snap[k] <= 8'd0;
      end
`ifdef URNA_APURACAO_TOTAL_EN
      r_total      <= 11'd0;
`endif
      r_max        <= 8'd0;
      r_max_idx    <= 3'd0;
      r_tie_flag   <= 1'b0;
      r_cnt        <= 4'd0;
      r_bin        <= 11'd0;
      r_acc        <= 16'd0;
      r_dwell      <= 32'd0;
      r_slot       <= 3'd0;
      r_bcd        <= 16'd0;
      r_show_valid <= 1'b0;
      r_winner     <= 3'd0;
      r_tie        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_winner <= 3'd0;
            r_tie    <= 1'b0;
            r_bcd    <= 16'd0;
            r_state  <= S_SNAP;
          end
        end
        S_SNAP: begin
          r_snap[0]  <= i_c1;
          r_snap[1]  <= i_c2;
          r_snap[2]  <= i_c3;
          r_snap[3]  <= i_c4;
          r_snap[4]  <= i_nulo;
`ifdef URNA_APURACAO_TOTAL_EN
          r_total    <= 11'(i_c1) + 11'(i_c2) + 11'(i_c3) + 11'(i_c4) + 11'(i_nulo);
`endif
          r_max      <= 8'd0;
          r_max_idx  <= 3'd0;
          r_tie_flag <= 1'b0;
          r_cnt      <= 4'd0;
          r_state    <= S_CMP;
        end
        S_CMP: begin
          r_max      <= w_max_nx;
          r_max_idx  <= w_idx_nx;
          r_tie_flag <= w_tie_nx;
          r_cnt      <= r_cnt + 4'd1;
          if (r_cnt == 4'd3) begin
            if (w_max_nx == 8'd0) begin
              r_winner <= 3'd0;
              r_tie    <= 1'b0;
            end else if (w_tie_nx) begin
              r_winner <= 3'd0;
              r_tie    <= 1'b1;
            end else begin
              r_winner <= w_idx_nx;
              r_tie    <= 1'b0;
            end
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_bin   <= w_slot_val;
          r_acc   <= 16'd0;
          r_cnt   <= 4'd0;
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_acc <= w_acc_nx;
          r_bin <= w_bin_nx;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) begin
            r_bcd        <= w_acc_nx;
            r_show_valid <= 1'b1;
            r_dwell      <= 32'd0;
            r_state      <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (i_skip || (r_dwell == DWELL_TC)) begin
            r_show_valid <= 1'b0;
            if (r_slot == LAST_SLOT) begin
              r_state <= S_DONE;
            end else begin
              r_slot  <= r_slot + 3'd1;
              r_state <= S_LOAD;
            end
          end else begin
            r_dwell <= r_dwell + 32'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_slot  <= 3'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_slot       = r_slot;
  assign o_bcd        = r_bcd;
  assign o_show_valid = r_show_valid;
  assign o_winner     = r_winner;
  assign o_tie        = r_tie;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule

// File: tb/tb_urna_apuracao.sv
// tb/tb_urna_apuracao.sv - scoreboard bench for urna_apuracao (either URNA_APURACAO_TOTAL_EN build)
module tb_urna_apuracao;
  localparam int D = 4;
`ifdef URNA_APURACAO_TOTAL_EN
  localparam int N = 6;
`else
  localparam int N = 5;
`endif

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_skip = 1'b0;
  logic [7:0]  i_c1 = '0, i_c2 = '0, i_c3 = '0, i_c4 = '0, i_nulo = '0;
  logic [2:0]  o_slot;
  logic [15:0] o_bcd;
  logic        o_show_valid;
  logic [2:0]  o_winner;
  logic        o_tie;
  logic        o_busy;
  logic        o_done;

  urna_apuracao #(.DWELL(D)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_skip(i_skip),
    .i_c1(i_c1), .i_c2(i_c2), .i_c3(i_c3), .i_c4(i_c4), .i_nulo(i_nulo),
    .o_slot(o_slot), .o_bcd(o_bcd), .o_show_valid(o_show_valid),
    .o_winner(o_winner), .o_tie(o_tie), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int slot; int bcd; int rise; int len; } show_t;
  typedef struct { int at; int winner; int tie; } done_t;
  show_t show_q[$];
  done_t done_q[$];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a slot or a Done pulse.
  bit prev_sv = 1'b0;
  int run_len = 0;
  int exp_len = 0;
  always @(negedge clk) begin
    if (o_show_valid && !prev_sv) begin
      if (show_q.size() == 0) begin
        check("unexpected_show", 1, 0);
      end else begin
        show_t e;
        e = show_q.pop_front();
        check("slot", int'(o_slot), e.slot);
        check("bcd", int'(o_bcd), e.bcd);
        check("show_rise_cycle", cyc, e.rise);
        exp_len = e.len;
      end
      run_len = 1;
    end else if (o_show_valid) begin
      run_len++;
    end else if (prev_sv) begin
      check("show_len", run_len, exp_len);
    end
    prev_sv = o_show_valid;
    if (o_done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        check("done_cycle", cyc, d.at);
        check("done_winner", int'(o_winner), d.winner);
        check("done_tie", int'(o_tie), d.tie);
        check("done_busy", int'(o_busy), 0);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // stop < N: reset is asserted during CONV of slot 'stop'.
  task automatic run(input int a, input int b, input int c, input int d, input int n,
                     input bit skip, input int stop, input bit perturb);
    int vals[6];
    int mx, cnt_max, widx, ew, et, t0, per;
    bit seen;
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d; vals[4] = n;
    vals[5] = a + b + c + d + n;
    mx = 0; widx = 0;
    for (int k = 0; k < 4; k++) if (vals[k] > mx) begin mx = vals[k]; widx = k + 1; end
    cnt_max = 0;
    for (int k = 0; k < 4; k++) if (vals[k] == mx) cnt_max++;
    if (mx == 0) begin ew = 0; et = 0; end
    else if (cnt_max > 1) begin ew = 0; et = 1; end
    else begin ew = widx; et = 0; end
    per = 12 + (skip ? 1 : D);

    @(negedge clk);
    i_c1 = 8'(a); i_c2 = 8'(b); i_c3 = 8'(c); i_c4 = 8'(d); i_nulo = 8'(n);
    i_skip = skip;
    i_start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    i_start = 1'b0;
    for (int k = 0; k < N && k < stop; k++)
      show_q.push_back('{k, to_bcd(vals[k]), t0 + 17 + k * per, skip ? 1 : D});
    if (stop >= N) done_q.push_back('{t0 + 6 + N * per, ew, et});

    if (perturb) begin
      wait_cyc(t0 + 2);
      i_c1 = 8'd200;
    end
    wait_cyc(t0 + 5);
    check("winner_after_cmp", int'(o_winner), ew);
    check("tie_after_cmp", int'(o_tie), et);
    if (perturb) begin
      wait_cyc(t0 + 18);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end

    if (stop < N) begin
      wait_cyc(t0 + 6 + stop * per + 3);
      i_reset = 1'b1;
      @(posedge clk); #1;
      check("reset_mid_outputs", int'({o_slot, o_bcd, o_show_valid, o_winner, o_tie, o_busy, o_done}), 0);
      check("reset_mid_busy", int'(o_busy), 0);
      @(negedge clk);
      i_reset = 1'b0;
    end else begin
      seen = 1'b0;
      for (int k = 0; k < N * per + 100 && !seen; k++) begin
        @(negedge clk);
        if (o_done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 0, 1);
    end
    i_skip = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({o_slot, o_bcd, o_show_valid, o_winner, o_tie, o_busy, o_done}), 0);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);

    run(3, 7, 2, 0, 5, 1'b0, N, 1'b0);
    run(3, 7, 2, 0, 5, 1'b0, N, 1'b1);
    run(9, 1, 9, 0, 4, 1'b0, N, 1'b0);
    run(0, 0, 0, 0, 0, 1'b0, N, 1'b0);
    run(255, 255, 255, 255, 255, 1'b0, N, 1'b0);
    run(0, 0, 0, 17, 99, 1'b0, N, 1'b0);
    run(3, 7, 2, 0, 5, 1'b1, N, 1'b0);
    run(3, 7, 2, 0, 5, 1'b0, 2, 1'b0);
    run(3, 7, 2, 0, 5, 1'b0, N, 1'b0);
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0)
        run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 255), r == 4, N, 1'b0);
      else
        run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, N, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("queues_drained", show_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
